serializer_tx: RTL and testbench

Transmit-side counterpart of the bit-serial deserializer. Accepts one byte per parallel handshake and emits it LSB-first as single-bit strobes: `data_out` is valid while `write_out` pulses for one cycle, followed by idle gap cycles. This matches the pattern the deserializer input expects. It sits between a byte source (e.g. the queue output `fila_data_out`) and the `data_in`/`write_in` pins of a receiving Top, and honours the receiver's `status_out` as back-pressure.

---
 rtl/serializer_pkg.sv | 18 +
 rtl/serializer_tx.sv | 106 ++++++++++
 tb/tb_serializer_tx.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serializer_pkg.sv
// Shared types and helpers for the bit-serial transmitter.
package serializer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_t;

  localparam int DATA_W_DEF = 8;
  localparam int GAP_DEF    = 1;

  // Even parity over a zero-extended word (XOR of all bits).
  function automatic logic even_parity(input logic [63:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/serializer_tx.sv
// Byte-to-bit-strobe transmitter: one write_out pulse per bit, LSB first, then idle gap.
// Optional macro SERIALIZER_TX_PARITY_EN appends an even-parity strobe after the data bits.
module serializer_tx
  import serializer_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int GAP_CYCLES = GAP_DEF
) (
  input  logic              clk_1MHz,
  input  logic              reset,
  input  logic [DATA_W-1:0] byte_in,
  input  logic              byte_valid_in,
  output logic              ready_out,
  input  logic              busy_in,
  output logic              data_out,
  output logic              write_out,
  output logic              done_out,
  output logic              tx_active_out
);

`ifdef SERIALIZER_TX_PARITY_EN
  localparam int NBITS = DATA_W + 1;
`else
  localparam int NBITS = DATA_W;
`endif
  localparam int BCW = $clog2(NBITS + 1);
  localparam int GCW = $clog2(GAP_CYCLES + 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(NBITS);
  localparam logic [GCW-1:0] GAP_LAST = GCW'(GAP_CYCLES - 1);

  tx_state_t        state;
  tx_state_t        state_nxt;
  logic [NBITS-1:0] shreg;
  logic [NBITS-1:0] shreg_load;
  logic [BCW-1:0]   bit_cnt;
  logic [GCW-1:0]   gap_cnt;
  logic             last_bit;
  logic             done_r;
  logic             accept;
  logic             gap_done;
  logic             bits_done;

`ifdef SERIALIZER_TX_PARITY_EN
  assign shreg_load = {even_parity(64'(byte_in)), byte_in};
`else
  assign shreg_load = byte_in;
`endif

  assign ready_out     = (state == IDLE) && !busy_in && !reset;
  assign accept        = byte_valid_in && ready_out;
  assign gap_done      = (gap_cnt == GAP_LAST);
  assign bits_done     = (bit_cnt == BIT_LAST);
  assign write_out     = (state == SEND);
  assign data_out      = (state == SEND) ? shreg[0] : last_bit;
  assign done_out      = done_r;
  assign tx_active_out = (state != IDLE);

  // busy_in only gates leaving GAP towards another strobe; it never delays completion.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = SEND;
      SEND: state_nxt = GAP;
      GAP: begin
        if (gap_done) begin
          if (bits_done)     state_nxt = IDLE;
          else if (!busy_in) state_nxt = SEND;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_1MHz) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      last_bit <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_r <= (state == GAP) && (state_nxt == IDLE);
      case (state)
        IDLE: begin
          if (accept) begin
            shreg   <= shreg_load;
            bit_cnt <= '0;
          end
        end
        SEND: begin
          shreg    <= {1'b0, shreg[NBITS-1:1]};
          last_bit <= shreg[0];
          gap_cnt  <= '0;
          if (!bits_done) bit_cnt <= bit_cnt + 1'b1;
        end
        GAP: begin
          if (!gap_done) gap_cnt <= gap_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serializer_tx.sv
// Directed self-checking bench for serializer_tx (optionally with SERIALIZER_TX_PARITY_EN).
module tb_serializer_tx;

  localparam int DW = 8;
  localparam int GC = 1;
`ifdef SERIALIZER_TX_PARITY_EN
  localparam int NB = DW + 1;
`else
  localparam int NB = DW;
`endif
  localparam int WORD_CYC = NB * (1 + GC);

  logic          clk_1MHz = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] byte_in = '0;
  logic          byte_valid_in = 1'b0;
  logic          busy_in = 1'b0;
  logic          ready_out, data_out, write_out, done_out, tx_active_out;

  serializer_tx #(.DATA_W(DW), .GAP_CYCLES(GC)) dut (
    .clk_1MHz      (clk_1MHz),
    .reset         (reset),
    .byte_in       (byte_in),
    .byte_valid_in (byte_valid_in),
    .ready_out     (ready_out),
    .busy_in       (busy_in),
    .data_out      (data_out),
    .write_out     (write_out),
    .done_out      (done_out),
    .tx_active_out (tx_active_out)
  );

  always #5 clk_1MHz = ~clk_1MHz;

  int cyc = 0;
  always @(posedge clk_1MHz) cyc <= cyc + 1;

  typedef struct { int c; logic b; } strobe_t;
  strobe_t str_q[$];
  int      done_q[$];
  int      acc_q[$];
  int      active_cnt = 0;

  // Passive monitor, sampled mid-cycle.
  always @(negedge clk_1MHz) begin
    if (write_out) str_q.push_back('{cyc, data_out});
    if (done_out) done_q.push_back(cyc);
    if (byte_valid_in && ready_out) acc_q.push_back(cyc);
    if (tx_active_out) active_cnt++;
  end

  typedef struct { logic [DW-1:0] word; logic [DW-1:0] exp_byte; logic exp_par; } vec_t;
  vec_t vec [7];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_1MHz);
    #1;
  endtask

  task automatic clear_logs;
    str_q.delete();
    done_q.delete();
    acc_q.delete();
    active_cnt = 0;
  endtask

  task automatic wait_done(input int n, input int budget);
    int t = 0;
    while (done_q.size() < n && t < budget) begin
      tick;
      t++;
    end
    chk("done_count", done_q.size(), n);
  endtask

  task automatic wait_strobes(input int n, input int budget);
    int t = 0;
    while (str_q.size() < n && t < budget) begin
      tick;
      t++;
    end
    chk("strobe_wait", (str_q.size() >= n), 1);
  endtask

  task automatic start_word(input logic [DW-1:0] w);
    int t = 0;
    clear_logs;
    byte_in = w;
    byte_valid_in = 1'b1;
    while (acc_q.size() == 0 && t < 10) begin
      tick;
      t++;
    end
    byte_valid_in = 1'b0;
    byte_in = ~w;
    chk("accept", acc_q.size(), 1);
  endtask

  // Reassemble word number wi from the strobe log (NB strobes per word).
  function automatic logic [DW-1:0] word_at(input int wi);
    logic [DW-1:0] r = '0;
    for (int i = 0; i < DW; i++)
      if (wi * NB + i < str_q.size()) r[i] = str_q[wi * NB + i].b;
    return r;
  endfunction

  task automatic check_word(input string tag, input logic [DW-1:0] exp_byte, input logic exp_par);
    int k;
    if (acc_q.size() == 0 || done_q.size() == 0) begin
      chk({tag, "_logs"}, 0, 1);
      return;
    end
    k = acc_q[0];
    chk({tag, "_nstrobe"}, str_q.size(), NB);
    for (int i = 0; i < NB && i < str_q.size(); i++)
      chk({tag, "_strobe_cyc"}, str_q[i].c - k, 1 + i * (1 + GC));
    chk({tag, "_byte"}, word_at(0), exp_byte);
`ifdef SERIALIZER_TX_PARITY_EN
    if (str_q.size() >= NB) chk({tag, "_parity"}, str_q[DW].b, exp_par);
`else
    if (exp_par === 1'bx) chk({tag, "_parity_x"}, 0, 1);
`endif
    chk({tag, "_done_cyc"}, done_q[0] - k, WORD_CYC + 1);
    chk({tag, "_active_cycles"}, active_cnt, WORD_CYC);
  endtask

  initial begin
    int t;
    int n;
    int f;
    vec[0] = '{8'hAB, 8'hAB, 1'b1};
    vec[1] = '{8'h00, 8'h00, 1'b0};
    vec[2] = '{8'hFF, 8'hFF, 1'b0};
    vec[3] = '{8'h5A, 8'h5A, 1'b0};
    vec[4] = '{8'h3C, 8'h3C, 1'b0};
    vec[5] = '{8'h01, 8'h01, 1'b1};
    vec[6] = '{8'h03, 8'h03, 1'b0};

    // Reset state
    repeat (2) tick;
    chk("rst_ready", ready_out, 0);
    chk("rst_write", write_out, 0);
    chk("rst_done", done_out, 0);
    chk("rst_active", tx_active_out, 0);
    chk("rst_data", data_out, 0);
    reset = 1'b0;
    tick;
    chk("post_rst_ready", ready_out, 1);
    busy_in = 1'b1;
    #1;
    chk("idle_busy_ready", ready_out, 0);
    busy_in = 1'b0;
    #1;

    // Single words from the table
    for (int v = 0; v < 7; v++) begin
      start_word(vec[v].word);
      wait_done(1, 60);
      check_word("single", vec[v].exp_byte, vec[v].exp_par);
      repeat (2) tick;
    end

    // Back-to-back: valid held, next word offered as soon as the previous is taken
    clear_logs;
    t = 0;
    while (done_q.size() < 4 && t < 300) begin
      n = acc_q.size();
      if (n < 4) begin
        byte_in = vec[n].word;
        byte_valid_in = 1'b1;
      end else begin
        byte_valid_in = 1'b0;
      end
      tick;
      t++;
    end
    byte_valid_in = 1'b0;
    chk("b2b_done_count", done_q.size(), 4);
    chk("b2b_accepts", acc_q.size(), 4);
    chk("b2b_strobes", str_q.size(), 4 * NB);
    for (int i = 1; i < 4; i++)
      if (i < acc_q.size() && i - 1 < done_q.size())
        chk("b2b_accept_on_done", acc_q[i], done_q[i-1]);
    for (int i = 0; i < 4; i++)
      chk("b2b_byte", word_at(i), vec[i].exp_byte);
    repeat (2) tick;

    // Back-pressure stall after the 3rd strobe
    start_word(8'hAB);
    wait_strobes(3, 20);
    busy_in = 1'b1;
    repeat (5) tick;
    chk("stall_write", write_out, 0);
    chk("stall_active", tx_active_out, 1);
    chk("stall_ready", ready_out, 0);
    repeat (5) tick;
    busy_in = 1'b0;
    f = cyc;
    wait_done(1, 60);
    chk("stall_nstrobe", str_q.size(), NB);
    if (str_q.size() >= 4) begin
      chk("stall_4th_cyc", str_q[3].c - f, 1);
      chk("stall_4th_bit", str_q[3].b, 1);
    end
    chk("stall_byte", word_at(0), 8'hAB);
    repeat (2) tick;

    // Reset asserted for one cycle during the 5th strobe
    start_word(8'hAB);
    wait_strobes(4, 20);
    tick;
    chk("abort_in_send", write_out, 1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("abort_write", write_out, 0);
    chk("abort_active", tx_active_out, 0);
    chk("abort_data", data_out, 0);
    chk("abort_done", done_out, 0);
    repeat (25) tick;
    chk("abort_no_done", done_q.size(), 0);
    chk("abort_strobes", str_q.size(), 5);
    start_word(8'h3C);
    wait_done(1, 60);
    check_word("after_abort", 8'h3C, 1'b0);
    repeat (2) tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=0", cyc);
    $fatal(1, "timeout");
  end

endmodule
